// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_e;

    // Pipeline register enables/flushes plus the data-memory request
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic memwb_flush;
        logic dmem_req;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_OFF = '0;

    localparam pipe_ctrl_t CTRL_FLOW = '{
        pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
        ifid_flush: 1'b0, idex_flush: 1'b0, memwb_flush: 1'b0, dmem_req: 1'b0
    };

    // Front of the pipe frozen; a bubble enters MEM/WB while memory is busy
    localparam pipe_ctrl_t CTRL_MEM_STALL = '{
        pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0, memwb_en: 1'b1,
        ifid_flush: 1'b0, idex_flush: 1'b0, memwb_flush: 1'b1, dmem_req: 1'b1
    };

endpackage

// File: rtl/load_use_detect.sv
// Flags an ID instruction that reads the destination of a load currently in EX.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] i_id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] i_id_rs2_addr,
    input  logic                  i_id_uses_rs1,
    input  logic                  i_id_uses_rs2,
    input  logic                  i_ex_memRead,
    input  logic [REG_ADDR_W-1:0] i_ex_rd_addr,
    output logic                  o_load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit  = i_id_uses_rs1 && (i_id_rs1_addr == i_ex_rd_addr);
    assign w_rs2_hit  = i_id_uses_rs2 && (i_id_rs2_addr == i_ex_rd_addr);
    assign o_load_use = i_ex_memRead && (i_ex_rd_addr != REG_ZERO) && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use, taken branch,
// multi-cycle data memory with wait timeout, and a saturating stall counter.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [REG_ADDR_W-1:0] i_id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] i_id_rs2_addr,
    input  logic                  i_id_uses_rs1,
    input  logic                  i_id_uses_rs2,
    input  logic                  i_ex_memRead,
    input  logic [REG_ADDR_W-1:0] i_ex_rd_addr,
    input  logic                  i_ex_branch_taken,
    input  logic                  i_mem_memRead,
    input  logic                  i_mem_memWrite,
    input  logic                  i_dmem_ack,
    output logic                  o_dmem_req,
    output logic                  o_pc_en,
    output logic                  o_ifid_en,
    output logic                  o_idex_en,
    output logic                  o_exmem_en,
    output logic                  o_memwb_en,
    output logic                  o_ifid_flush,
    output logic                  o_idex_flush,
    output logic                  o_memwb_flush,
    output logic                  o_mem_err,
    output logic [CNT_W-1:0]      o_stall_cnt
);

    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [WAIT_W-1:0] w_wait_cnt_nxt;
    logic              r_mem_err;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              w_mem_op;
    logic              w_load_use;
    logic              w_stall_inc;
    pipe_ctrl_t        w_hzd_ctrl;
    pipe_ctrl_t        w_ctrl;

    load_use_detect u_load_use_detect (
        .i_id_rs1_addr (i_id_rs1_addr),
        .i_id_rs2_addr (i_id_rs2_addr),
        .i_id_uses_rs1 (i_id_uses_rs1),
        .i_id_uses_rs2 (i_id_uses_rs2),
        .i_ex_memRead  (i_ex_memRead),
        .i_ex_rd_addr  (i_ex_rd_addr),
        .o_load_use    (w_load_use)
    );

    assign w_mem_op = i_mem_memRead || i_mem_memWrite;

    // Branch/load-use resolution used whenever memory is not holding the pipe
    always_comb begin
        w_hzd_ctrl = CTRL_FLOW;
        if (i_ex_branch_taken) begin
            w_hzd_ctrl.ifid_flush = 1'b1;
            w_hzd_ctrl.idex_flush = 1'b1;
        end else if (w_load_use) begin
            w_hzd_ctrl.pc_en      = 1'b0;
            w_hzd_ctrl.ifid_en    = 1'b0;
            w_hzd_ctrl.idex_flush = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    // Next state, wait counter and control outputs; all controls low in reset
    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_ctrl         = CTRL_OFF;
        if (i_rst_n) begin
            unique case (r_state)
                RUN: begin
                    if (w_mem_op && !i_dmem_ack) begin
                        w_state_nxt    = MEM_WAIT;
                        w_wait_cnt_nxt = WAIT_W'(1);
                        w_ctrl         = CTRL_MEM_STALL;
                    end else begin
                        w_ctrl          = w_hzd_ctrl;
                        w_ctrl.dmem_req = w_mem_op;
                    end
                end
                MEM_WAIT: begin
                    if (i_dmem_ack) begin
                        w_state_nxt     = RUN;
                        w_wait_cnt_nxt  = '0;
                        w_ctrl          = w_hzd_ctrl;
                        w_ctrl.dmem_req = 1'b1;
                    end else if (r_wait_cnt == WAIT_W'(MAX_WAIT)) begin
                        w_state_nxt = FAULT;
                        w_ctrl      = CTRL_MEM_STALL;
                    end else begin
                        w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
                        w_ctrl         = CTRL_MEM_STALL;
                    end
                end
                FAULT: begin
                    w_ctrl = CTRL_OFF;
                end
                default: begin
                    w_state_nxt = RUN;
                end
            endcase
        end
    end

    assign w_stall_inc = (r_state != FAULT) && !w_ctrl.pc_en;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem_err   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (w_state_nxt == FAULT) begin
                r_mem_err <= 1'b1;
            end
            if (w_stall_inc && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign o_pc_en       = w_ctrl.pc_en;
    assign o_ifid_en     = w_ctrl.ifid_en;
    assign o_idex_en     = w_ctrl.idex_en;
    assign o_exmem_en    = w_ctrl.exmem_en;
    assign o_memwb_en    = w_ctrl.memwb_en;
    assign o_ifid_flush  = w_ctrl.ifid_flush;
    assign o_idex_flush  = w_ctrl.idex_flush;
    assign o_memwb_flush = w_ctrl.memwb_flush;
    assign o_dmem_req    = w_ctrl.dmem_req;
    assign o_mem_err     = r_mem_err;
    assign o_stall_cnt   = r_stall_cnt;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage 64-bit RISC-V pipeline. It drives the enable and flush inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, covering three cases: load-use hazards, taken branches resolved in EX, and multi-cycle data-memory accesses. It also owns the data-memory request/acknowledge handshake, a wait-timeout fault state and a saturating stall-cycle counter.

## Interface
- MAX_WAIT, 15, maximum MEM_WAIT cycles without i_dmem_ack before FAULT (≥1)
- CNT_W, 32, width of stall-cycle counter
- i_clk  in  1  clock
- i_rst_n  in  1  reset i_rst_n, asynchronous, active-low; clock i_clk
- i_id_rs1_addr / i_id_rs2_addr  in  5  source registers of instruction in ID
- i_id_uses_rs1 / i_id_uses_rs2  in  1  ID instruction reads rs1 / rs2
- i_ex_memRead  in  1  instruction in EX is a load
- i_ex_rd_addr  in  5  destination register of EX instruction
- i_ex_branch_taken  in  1  branch/jump in EX resolved taken
- i_mem_memRead / i_mem_memWrite  in  1  EX/MEM register holds a load / store
- i_dmem_ack  in  1  data memory completes current access this cycle
- o_dmem_req  out  1  data-memory access request
- o_pc_en, o_ifid_en, o_idex_en, o_exmem_en, o_memwb_en  out  1  register load enables
- o_ifid_flush, o_idex_flush, o_memwb_flush  out  1  load bubble (all zero) at next edge; flush overrides enable
- o_mem_err  out  1  timeout fault, sticky until reset
- o_stall_cnt  out  CNT_W  saturating count of cycles with o_pc_en=0 outside reset/FAULT

## Operation
- mem_op = i_mem_memRead | i_mem_memWrite.
- load_use = i_ex_memRead & i_ex_rd_addr≠0 & ((i_id_uses_rs1 & rs1==rd) | (i_id_uses_rs2 & rs2==rd)).
- Priority is mem_stall > branch > load_use. Cases:
  - mem_stall:
    - Condition: mem_op & ~i_dmem_ack, in RUN or MEM_WAIT.
    - PC, IF/ID, ID/EX and EX/MEM enables = 0; o_memwb_flush = 1; all other flushes = 0.
    - Branch and load-use are ignored this cycle and re-evaluated after release, because their inputs are frozen.
  - branch:
    - All enables = 1 (PC loads target); o_ifid_flush = 1, o_idex_flush = 1.
    - A simultaneous load_use is suppressed (the ID instruction is squashed).
  - load_use:
    - o_pc_en = 0, o_ifid_en = 0, o_idex_flush = 1; EX/MEM and MEM/WB enabled.
  - Otherwise: all enables = 1, all flushes = 0.
- o_dmem_req = mem_op in RUN/MEM_WAIT; it is held high throughout MEM_WAIT.
- FSM (registered state, reset → RUN):
  - RUN → MEM_WAIT when mem_op & ~i_dmem_ack; wait_cnt ← 1.
  - RUN stays RUN when there is no mem_op, or mem_op & i_dmem_ack (zero-wait access, no stall).
  - MEM_WAIT → RUN on i_dmem_ack. Stalls release in the ack cycle; wait_cnt ← 0.
  - MEM_WAIT → FAULT when ~i_dmem_ack and wait_cnt == MAX_WAIT. Otherwise wait_cnt increments.
  - FAULT is terminal until reset:
    - all enables = 0, all flushes = 0, o_dmem_req = 0;
    - o_mem_err = 1; i_dmem_ack is ignored.
- o_stall_cnt increments on every RUN/MEM_WAIT cycle with o_pc_en = 0 and saturates at all-ones.
- Width of wait_cnt is $clog2(MAX_WAIT+1).

## Timing
- Control outputs are combinational from the inputs and registered state. State, wait_cnt, o_mem_err and o_stall_cnt are registered on posedge i_clk.
- Values while i_rst_n is low:
  - state = RUN, wait_cnt = 0, o_mem_err = 0, o_stall_cnt = 0;
  - all enables = 0, all flushes = 0, o_dmem_req = 0.
- Reset asserted mid-MEM_WAIT or in FAULT returns to RUN immediately and drops o_dmem_req asynchronously.
- Load-use costs exactly 1 bubble. A taken branch costs 2 squashed slots.
- An N-cycle memory access (ack in the N-th cycle of request) costs N−1 stall cycles.
- An ack arriving with mem_op = 0 is ignored.

## Structure
- Package pipe_ctrl_pkg:
  - state enum {RUN, MEM_WAIT, FAULT};
  - REG_ADDR_W = 5; REG_ZERO = 5'd0;
  - a packed struct for the 9 enable/flush outputs.
- One combinational sub-module, load_use_detect, computes load_use. The FSM, priority mux and counters live in pipe_hazard_ctrl.

## Test plan
- Load-use:
  - Stimulus: EX load rd=5; ID add rs1=5 (uses_rs1=1).
  - Response: one cycle with o_pc_en=0, o_ifid_en=0, o_idex_flush=1; o_stall_cnt goes 0→1.
  - Repeat with rd=0: no stall.
- Branch + load-use together:
  - Stimulus: i_ex_branch_taken=1 with a matching load_use.
  - Response: o_ifid_flush=o_idex_flush=1, o_pc_en=1; o_stall_cnt unchanged.
- 3-cycle store (MAX_WAIT=4):
  - Stimulus: i_mem_memWrite=1, ack in the 3rd request cycle.
  - Response: 2 cycles with front enables=0 and o_memwb_flush=1; release in the ack cycle; o_stall_cnt=2.
- Timeout (MAX_WAIT=4):
  - Stimulus: load with no ack.
  - Response: FAULT entered after 5 request cycles; o_mem_err=1 with all enables 0; a later ack has no effect.
  - Then assert i_rst_n=0: o_mem_err=0 and state RUN.
- Mem stall during branch:
  - Stimulus: i_mem_memRead=1 with no ack, plus i_ex_branch_taken=1.
  - Response: no flushes of IF/ID or ID/EX while stalled.
  - After ack, branch flushes apply in that same cycle.
- Counter saturation (CNT_W=4):
  - Stimulus: 20 load-use stall cycles.
  - Response: o_stall_cnt=15.
